// File: rtl/rank_calculator_if.sv
// Sample-in / ranked-window-out bundle between the sample source,
// the rank calculator and the downstream rank selector.
interface rank_calculator_if #(
  parameter int N         = 3,
  parameter int data_bits = 8,
  parameter int rank_bits = 2
);
  logic                      clear;
  logic                      in_valid;
  logic [data_bits-1:0]      in_data;
  logic                      out_valid;
  logic [data_bits*N-1:0]    out_s;
  logic [rank_bits*N-1:0]    out_r;

  modport master (
    output clear, in_valid, in_data,
    input  out_valid, out_s, out_r
  );

  modport slave (
    input  clear, in_valid, in_data,
    output out_valid, out_s, out_r
  );
endinterface

// File: rtl/rank_calculator.sv
// Sliding-window ranking stage: keeps the last N samples, gives every slot a
// unique rank (ties broken by slot position) and registers window + ranks
// one cycle after each accepted sample.
module rank_calculator #(
  parameter int N         = 3,
  parameter int data_bits = 8,
  parameter int rank_bits = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  rank_calculator_if.slave   bus
);

  localparam int cnt_bits = $clog2(N + 1);

  logic [data_bits-1:0] window    [N];
  logic [rank_bits-1:0] rank_next [N];
  logic [cnt_bits-1:0]  fill_count;
  logic                 load_pending;
  logic                 accept;

  assign accept = bus.in_valid && !bus.clear;

  // Stage 1: shift the accepted sample into slot 0; clear flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) window[i] <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < N; i++) window[i] <= '0;
    end else if (bus.in_valid) begin
      for (int i = N - 1; i > 0; i--) window[i] <= window[i-1];
      window[0] <= bus.in_data;
    end
  end

  // Fill counter saturates at N and remembers that a load is due next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count   <= '0;
      load_pending <= 1'b0;
    end else begin
      load_pending <= accept;
      if (bus.clear) begin
        fill_count <= '0;
      end else if (bus.in_valid && (fill_count != cnt_bits'(N))) begin
        fill_count <= fill_count + cnt_bits'(1);
      end
    end
  end

  // Pairwise ranking: count smaller entries, and equal entries in lower slots.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rank_next[i] = '0;
      for (int j = 0; j < N; j++) begin
        if ((j != i) &&
            ((window[j] < window[i]) || ((window[j] == window[i]) && (j < i)))) begin
          rank_next[i] = rank_next[i] + rank_bits'(1);
        end
      end
    end
  end

  // Stage 2: register window and ranks the cycle after a capture; clear suppresses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_s     <= '0;
      bus.out_r     <= '0;
    end else if (bus.clear) begin
      bus.out_valid <= 1'b0;
    end else if (load_pending) begin
      bus.out_valid <= (fill_count == cnt_bits'(N));
      for (int i = 0; i < N; i++) begin
        bus.out_s[data_bits*i +: data_bits] <= window[i];
        bus.out_r[rank_bits*i +: rank_bits] <= rank_next[i];
      end
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
